// File: rtl/exp_post_adjust_pkg.sv
// Shared definitions for the MAF exponent post-adjust path: lane widths, EMAX limits and the
// mode encoding carried with each beat.
package exp_post_adjust_pkg;

    localparam int unsigned ExpW  = 12;
    localparam int unsigned LaneW = 6;

    localparam logic [ExpW-1:0]  EmaxW = 12'hFFE;
    localparam logic [LaneW-1:0] EmaxH = 6'h3E;

    typedef enum logic [1:0] {
        Mode1 = 2'd1,
        Mode2 = 2'd2,
        Mode3 = 2'd3
    } mode_e;

    // cont[1] wins over cont[0]; 2'b00 falls back to the single-lane mode.
    function automatic mode_e decode_mode(input logic [1:0] cont);
        if (cont[1]) begin
            return Mode3;
        end else if (cont[0]) begin
            return Mode2;
        end else begin
            return Mode1;
        end
    endfunction

endpackage

// File: rtl/exp_post_adjust_lane_adj.sv
// One lane of the stage-2 exponent adjust: add rounding carry, flag over/underflow.
// Optional saturation of the lane result is enabled by defining EXP_SAT_EN.
module exp_post_adjust_lane_adj #(
    parameter int unsigned     Width = 12,
    parameter logic [Width-1:0] Emax = '1
) (
    input  logic [Width+1:0] d_i,
    input  logic             inc_i,
    output logic [Width-1:0] e_o,
    output logic             ovf_o,
    output logic             udf_o
);

    logic [Width+1:0] r;

    // d_i is two's complement with two guard bits, so the carry add cannot wrap.
    assign r     = d_i + {{(Width + 1){1'b0}}, inc_i};
    assign udf_o = r[Width+1] | (r == '0);
    assign ovf_o = ~r[Width+1] & (r[Width:0] > {1'b0, Emax});

`ifdef EXP_SAT_EN
    always_comb begin
        e_o = r[Width-1:0];
        if (ovf_o) begin
            e_o = Emax;
        end else if (udf_o) begin
            e_o = '0;
        end
    end
`else
    assign e_o = r[Width-1:0];
`endif

endmodule

// File: rtl/exp_post_adjust.sv
// Two-stage valid/ready exponent post-adjust: stage 1 subtracts the normalisation shift,
// stage 2 adds the rounding carry and flags over/underflow per lane (EXP_SAT_EN saturates).
module exp_post_adjust
    import exp_post_adjust_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cont,
    input  logic [11:0] E_PRE_C,
    input  logic [11:0] LZC,
    input  logic [1:0]  RND_INC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] E_OUT,
    output logic [1:0]  OVF,
    output logic [1:0]  UDF
);

    logic        s1_adv, s2_adv;
    logic        s1_valid_q, s2_valid_q;
    mode_e       mode_q;
    logic [13:0] d_w_d, d_w_q;
    logic [7:0]  d_hi_d, d_hi_q, d_lo_d, d_lo_q;
    logic [1:0]  rnd_q;
    logic [11:0] e_d, e_q;
    logic [1:0]  ovf_d, ovf_q, udf_d, udf_q;
    logic [11:0] e_w;
    logic [5:0]  e_hi, e_lo;
    logic        ovf_w, udf_w, ovf_hi, udf_hi, ovf_lo, udf_lo;
    logic        unused_cont;

    assign unused_cont = cont[2];

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Lanes are computed separately so no borrow crosses bit 6 in mode 2.
    always_comb begin
        d_w_d  = {2'b00, E_PRE_C} - {2'b00, LZC};
        d_hi_d = {2'b00, E_PRE_C[11:6]} - {2'b00, LZC[11:6]};
        d_lo_d = {2'b00, E_PRE_C[5:0]} - {2'b00, LZC[5:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            mode_q     <= Mode1;
            d_w_q      <= '0;
            d_hi_q     <= '0;
            d_lo_q     <= '0;
            rnd_q      <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                mode_q <= decode_mode(cont[1:0]);
                d_w_q  <= d_w_d;
                d_hi_q <= d_hi_d;
                d_lo_q <= d_lo_d;
                rnd_q  <= RND_INC;
            end
        end
    end

    exp_post_adjust_lane_adj #(
        .Width (ExpW),
        .Emax  (EmaxW)
    ) u_lane_w (
        .d_i   (d_w_q),
        .inc_i (rnd_q[0]),
        .e_o   (e_w),
        .ovf_o (ovf_w),
        .udf_o (udf_w)
    );

    exp_post_adjust_lane_adj #(
        .Width (LaneW),
        .Emax  (EmaxH)
    ) u_lane_hi (
        .d_i   (d_hi_q),
        .inc_i (rnd_q[1]),
        .e_o   (e_hi),
        .ovf_o (ovf_hi),
        .udf_o (udf_hi)
    );

    exp_post_adjust_lane_adj #(
        .Width (LaneW),
        .Emax  (EmaxH)
    ) u_lane_lo (
        .d_i   (d_lo_q),
        .inc_i (rnd_q[0]),
        .e_o   (e_lo),
        .ovf_o (ovf_lo),
        .udf_o (udf_lo)
    );

    always_comb begin
        e_d   = e_w;
        ovf_d = {1'b0, ovf_w};
        udf_d = {1'b0, udf_w};
        if (mode_q == Mode2) begin
            e_d   = {e_hi, e_lo};
            ovf_d = {ovf_hi, ovf_lo};
            udf_d = {udf_hi, udf_lo};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            e_q        <= '0;
            ovf_q      <= '0;
            udf_q      <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                e_q   <= e_d;
                ovf_q <= ovf_d;
                udf_q <= udf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign E_OUT     = e_q;
    assign OVF       = ovf_q;
    assign UDF       = udf_q;

endmodule

// File: tb/tb_exp_post_adjust.sv
// Directed self-checking bench for exp_post_adjust; expectations follow EXP_SAT_EN if defined.
module tb_exp_post_adjust;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cont;
    logic [11:0] E_PRE_C;
    logic [11:0] LZC;
    logic [1:0]  RND_INC;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] E_OUT;
    logic [1:0]  OVF;
    logic [1:0]  UDF;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    exp_post_adjust dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cont      (cont),
        .E_PRE_C   (E_PRE_C),
        .LZC       (LZC),
        .RND_INC   (RND_INC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .E_OUT     (E_OUT),
        .OVF       (OVF),
        .UDF       (UDF)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One isolated beat with out_ready high; checks latency and all outputs.
    task automatic run_vec(input string tag, input logic [2:0] c, input logic [11:0] e,
                           input logic [11:0] l, input logic [1:0] inc,
                           input logic [11:0] exp_e, input logic [1:0] exp_ovf,
                           input logic [1:0] exp_udf);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cont      = c;
        E_PRE_C   = e;
        LZC       = l;
        RND_INC   = inc;
        #1;
        check_eq({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 16'(n), 16'd2);
        check_eq({tag, "_e_out"}, {4'd0, E_OUT}, {4'd0, exp_e});
        check_eq({tag, "_ovf"}, {14'd0, OVF}, {14'd0, exp_ovf});
        check_eq({tag, "_udf"}, {14'd0, UDF}, {14'd0, exp_udf});
    endtask

    initial begin
        int sent, rcv, stale;
        logic saw_stall, held_vld;
        logic [11:0] held_e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cont      = 3'b000;
        E_PRE_C   = '0;
        LZC       = '0;
        RND_INC   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst_e_out", {4'd0, E_OUT}, 16'd0);
        check_eq("rst_flags", {12'd0, OVF, UDF}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", {15'd0, in_ready}, 16'd1);

        run_vec("m1_basic", 3'b000, 12'h400, 12'h003, 2'b00, 12'h3FD, 2'b00, 2'b00);
`ifdef EXP_SAT_EN
        run_vec("m2_lane_udf", 3'b001, {6'd20, 6'd5}, {6'd4, 6'd7}, 2'b01,
                12'h400, 2'b00, 2'b01);
        run_vec("m1_ovf", 3'b000, 12'hFFE, 12'h000, 2'b01, 12'hFFE, 2'b01, 2'b00);
        run_vec("m2_hi_ovf", 3'b001, {6'h3E, 6'd10}, {6'd0, 6'd2}, 2'b10,
                12'hF88, 2'b10, 2'b00);
        run_vec("m2_no_borrow", 3'b001, {6'd10, 6'd0}, {6'd0, 6'd1}, 2'b00,
                12'h280, 2'b00, 2'b01);
        run_vec("m1_neg", 3'b000, 12'h005, 12'h008, 2'b00, 12'h000, 2'b00, 2'b01);
`else
        run_vec("m2_lane_udf", 3'b001, {6'd20, 6'd5}, {6'd4, 6'd7}, 2'b01,
                12'h43F, 2'b00, 2'b01);
        run_vec("m1_ovf", 3'b000, 12'hFFE, 12'h000, 2'b01, 12'hFFF, 2'b01, 2'b00);
        run_vec("m2_hi_ovf", 3'b001, {6'h3E, 6'd10}, {6'd0, 6'd2}, 2'b10,
                12'hFC8, 2'b10, 2'b00);
        run_vec("m2_no_borrow", 3'b001, {6'd10, 6'd0}, {6'd0, 6'd1}, 2'b00,
                12'h2BF, 2'b00, 2'b01);
        run_vec("m1_neg", 3'b000, 12'h005, 12'h008, 2'b00, 12'hFFD, 2'b00, 2'b01);
`endif
        run_vec("m1_at_emax", 3'b000, 12'hFFE, 12'h000, 2'b00, 12'hFFE, 2'b00, 2'b00);
        run_vec("m3_zero", 3'b010, 12'h010, 12'h010, 2'b00, 12'h000, 2'b00, 2'b01);
        run_vec("m3_cont110", 3'b110, 12'h123, 12'h023, 2'b01, 12'h101, 2'b00, 2'b00);
        run_vec("m3_cont011", 3'b011, 12'h800, 12'h001, 2'b01, 12'h800, 2'b00, 2'b00);

        // Back-to-back stream with out_ready low on cycles 3..5.
        sent = 0;
        rcv = 0;
        saw_stall = 1'b0;
        held_vld = 1'b0;
        held_e = '0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            cont      = 3'b000;
            E_PRE_C   = 12'h100 + 12'(sent);
            LZC       = 12'h000;
            RND_INC   = 2'b00;
            #1;
            if (held_vld) check_eq("b2b_hold", {4'd0, E_OUT}, {4'd0, held_e});
            held_vld = out_valid && !out_ready;
            held_e   = E_OUT;
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                check_eq("b2b_order", {4'd0, E_OUT}, 16'h100 + 16'(rcv));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("b2b_sent", 16'(sent), 16'd8);
        check_eq("b2b_rcvd", 16'(rcv), 16'd8);
        check_eq("b2b_stall_seen", {15'd0, saw_stall}, 16'd1);
        check_eq("b2b_no_dup", {15'd0, out_valid}, 16'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            cont     = 3'b000;
            E_PRE_C  = (i == 0) ? 12'h222 : 12'h333;
            LZC      = 12'h000;
            RND_INC  = 2'b00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("pre_rst_full", {15'd0, out_valid}, 16'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_fly_out_valid", {15'd0, out_valid}, 16'd0);
        check_eq("rst_fly_e_out", {4'd0, E_OUT}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("rst_no_stale", 16'(stale), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
